// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 convolution datapath.
//   NUM_TAPS          : taps in one 3x3 window
//   TAP_WIDTH         : default bits per tap sample
//   collector_state_e : window_collector bank state (FILL / FULL)
//   tap_window_t      : one packed window, tap k in element [k]
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int NUM_TAPS  = 9;
  localparam int TAP_WIDTH = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } collector_state_e;

  typedef logic [NUM_TAPS-1:0][TAP_WIDTH-1:0] tap_window_t;

endpackage

// File: rtl/window_collector.sv
// ---------------------------------------------------------------------------
// window_collector
// Reassembles the nine per-tap lanes coming out of the pixel demux into one
// complete 3x3 window. The window is handed to the MAC stage over a single
// valid/ready port. A 9-slot fill bank sits behind a one-window output
// register, so the next window can fill while the current one is stalled.
// Lanes cannot be stalled. A sample that arrives for an occupied slot is
// dropped, and the sticky overrun flag is set.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   lane_data  : 9 tap samples, tap k at [k*WIDTH +: WIDTH]
//   lane_valid : per-tap valid, any combination per cycle
//   clear      : synchronous flush of bank, output register and overrun
//   win_data   : packed output window, tap k at [k*WIDTH +: WIDTH]
//   win_valid  : output window available
//   win_ready  : consumer takes the window when win_valid && win_ready
//   fill_mask  : occupied bank slots
//   overrun    : sticky, a lane sample was dropped
//   win_cnt    : windows accepted by the consumer, wraps
// ---------------------------------------------------------------------------
module window_collector
  import conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_TAPS*WIDTH-1:0]   lane_data,
  input  logic [NUM_TAPS-1:0]         lane_valid,
  input  logic                        clear,
  output logic [NUM_TAPS*WIDTH-1:0]   win_data,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [NUM_TAPS-1:0]         fill_mask,
  output logic                        overrun,
  output logic [CNT_W-1:0]            win_cnt
);

  typedef logic [NUM_TAPS-1:0][WIDTH-1:0] window_t;

  collector_state_e    r_state, w_nextState;
  window_t             r_bank, r_winData;
  window_t             w_laneTaps, w_nextBank, w_nextWinData;
  logic [NUM_TAPS-1:0] r_fillMask, w_nextFillMask;
  logic [NUM_TAPS-1:0] w_capture, w_drop;
  logic                r_winValid, w_nextWinValid;
  logic                r_overrun, w_nextOverrun;
  logic [CNT_W-1:0]    r_winCnt;
  logic                w_transfer, w_complete, w_slotFree, w_accept;

  assign w_laneTaps = lane_data;

  // A full bank can only take new samples in the cycle where it is moved
  // into the output register. That is the only cycle in which its slots
  // count as empty.
  assign w_transfer = (r_state == FULL) && win_ready;
  assign w_capture  = (r_state == FILL) ? (lane_valid & ~r_fillMask)
                    : (w_transfer ? lane_valid : '0);
  assign w_drop     = lane_valid & ~w_capture;
  assign w_complete = (r_state == FILL) && (&(r_fillMask | w_capture));
  assign w_slotFree = !r_winValid || win_ready;
  assign w_accept   = r_winValid && win_ready;

  // Each slot's next value: the new sample if it was captured, otherwise the
  // value it already holds.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_slot
    assign w_nextBank[k] = w_capture[k] ? w_laneTaps[k] : r_bank[k];
  end

  // Next-state logic. A completing window passes straight through to the
  // output register when that register is free, so there is no bubble.
  // Otherwise the bank holds the window in FULL. clear overrides everything
  // except the counter. A handshake seen by the consumer in the same cycle
  // as clear still counts.
  always_comb begin
    w_nextState    = r_state;
    w_nextFillMask = r_fillMask | w_capture;
    w_nextWinValid = r_winValid && !w_accept;
    w_nextWinData  = r_winData;
    w_nextOverrun  = r_overrun | (|w_drop);
    case (r_state)
      FILL: begin
        if (w_complete) begin
          if (w_slotFree) begin
            w_nextWinData  = w_nextBank;
            w_nextWinValid = 1'b1;
            w_nextFillMask = '0;
          end else begin
            w_nextState = FULL;
          end
        end
      end
      FULL: begin
        if (w_transfer) begin
          w_nextWinData  = r_bank;
          w_nextWinValid = 1'b1;
          w_nextFillMask = w_capture;
          w_nextState    = FILL;
        end
      end
      default: w_nextState = FILL;
    endcase
    if (clear) begin
      w_nextFillMask = '0;
      w_nextWinValid = 1'b0;
      w_nextOverrun  = 1'b0;
      w_nextState    = FILL;
    end
  end

  // State and datapath registers. The bank data is not cleared by clear,
  // because the empty fill mask already hides the stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FILL;
      r_bank     <= '0;
      r_fillMask <= '0;
      r_winData  <= '0;
      r_winValid <= 1'b0;
      r_overrun  <= 1'b0;
      r_winCnt   <= '0;
    end else begin
      r_state    <= w_nextState;
      r_bank     <= w_nextBank;
      r_fillMask <= w_nextFillMask;
      r_winData  <= w_nextWinData;
      r_winValid <= w_nextWinValid;
      r_overrun  <= w_nextOverrun;
      if (w_accept) begin
        r_winCnt <= r_winCnt + 1'b1;
      end
    end
  end

  assign win_data  = r_winData;
  assign win_valid = r_winValid;
  assign fill_mask = r_fillMask;
  assign overrun   = r_overrun;
  assign win_cnt   = r_winCnt;

endmodule

// File: tb/tb_window_collector.sv
// ---------------------------------------------------------------------------
// tb_window_collector
// Directed stimulus for window_collector. Expected windows are queued when
// the stimulus is issued. A negedge monitor pops one window per handshake
// and compares it. Flag and counter values are compared directly after
// each stimulus step.
// ---------------------------------------------------------------------------
module tb_window_collector;
  import conv_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      clear;
  logic [NUM_TAPS*WIDTH-1:0] lane_data;
  logic [NUM_TAPS-1:0]       lane_valid;
  logic [NUM_TAPS*WIDTH-1:0] win_data;
  logic                      win_valid;
  logic                      win_ready;
  logic [NUM_TAPS-1:0]       fill_mask;
  logic                      overrun;
  logic [CNT_W-1:0]          win_cnt;

  tap_window_t      expQ[$];
  int               errors    = 0;
  int               checks    = 0;
  int               monErrors = 0;
  int               monChecks = 0;
  logic [CNT_W-1:0] expCnt;

  window_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .lane_data (lane_data),
    .lane_valid(lane_valid),
    .clear     (clear),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .fill_mask (fill_mask),
    .overrun   (overrun),
    .win_cnt   (win_cnt)
  );

  always #5 clk = ~clk;

  // The monitor compares each accepted window against the oldest expected one.
  always @(negedge clk) begin
    tap_window_t e;
    if (!rst && win_valid && win_ready) begin
      monChecks++;
      if (expQ.size() == 0) begin
        monErrors++;
        $display("[TB] FAIL window: got %h, none expected", win_data);
      end else begin
        e = expQ.pop_front();
        if (win_data !== e) begin
          monErrors++;
          $display("[TB] FAIL window: got %h, want %h", win_data, e);
        end
      end
    end
  end

  function automatic tap_window_t mkWin(input logic [7:0] base, input logic [7:0] step);
    tap_window_t w;
    for (int k = 0; k < NUM_TAPS; k++) w[k] = base + step * 8'(k);
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_TAPS-1:0] mask, input tap_window_t taps);
    lane_valid = mask;
    lane_data  = taps;
    @(posedge clk);
    #1;
    lane_valid = '0;
    lane_data  = {NUM_TAPS{8'hEE}};
  endtask

  initial begin
    tap_window_t t, e, a, b;
    rst        = 1'b1;
    clear      = 1'b0;
    win_ready  = 1'b0;
    lane_valid = '0;
    lane_data  = '0;
    expCnt     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst fill_mask", 128'(fill_mask), 128'(0));
    checkOutput("rst win_valid", 128'(win_valid), 128'(0));
    checkOutput("rst overrun",   128'(overrun),   128'(0));
    checkOutput("rst win_cnt",   128'(win_cnt),   128'(0));
    checkOutput("rst win_data",  128'(win_data),  128'(0));

    // Sequential fill: one lane per cycle, values 10..90.
    win_ready = 1'b1;
    expQ.push_back(mkWin(8'd10, 8'd10));
    for (int k = 0; k < NUM_TAPS; k++) begin
      t    = {NUM_TAPS{8'hEE}};
      t[k] = 8'(10 * (k + 1));
      applyStimulus(9'b1 << k, t);
      if (k == 3) checkOutput("seq fill_mask", 128'(fill_mask), 128'(9'h00F));
    end
    checkOutput("seq win_valid", 128'(win_valid), 128'(1));
    checkOutput("seq fill_mask empty", 128'(fill_mask), 128'(0));
    checkOutput("seq overrun", 128'(overrun), 128'(0));
    applyStimulus('0, {NUM_TAPS{8'hEE}});
    expCnt = expCnt + 1'b1;
    checkOutput("seq consumed", 128'(win_valid), 128'(0));
    checkOutput("seq win_cnt", 128'(win_cnt), 128'(expCnt));

    // All lanes at once, three back-to-back windows.
    for (int i = 0; i < 3; i++) begin
      t = mkWin(8'(1 + 16 * i), 8'd1);
      expQ.push_back(t);
      applyStimulus(9'h1FF, t);
      checkOutput("b2b win_valid", 128'(win_valid), 128'(1));
    end
    applyStimulus('0, {NUM_TAPS{8'hEE}});
    expCnt = expCnt + 3'd3;
    checkOutput("b2b drained", 128'(win_valid), 128'(0));
    checkOutput("b2b win_cnt", 128'(win_cnt), 128'(expCnt));

    // Backpressure: A held in the output register, B held in the bank.
    win_ready = 1'b0;
    a = mkWin(8'h11, 8'h00);
    b = mkWin(8'h22, 8'h00);
    expQ.push_back(a);
    expQ.push_back(b);
    applyStimulus(9'h1FF, a);
    checkOutput("bp A valid", 128'(win_valid), 128'(1));
    checkOutput("bp A data", 128'(win_data), 128'(a));
    applyStimulus(9'h1FF, b);
    checkOutput("bp full mask", 128'(fill_mask), 128'(9'h1FF));
    checkOutput("bp A held", 128'(win_data), 128'(a));
    applyStimulus('0, {NUM_TAPS{8'hEE}});
    checkOutput("bp A stable", 128'(win_data), 128'(a));

    // Overrun while FULL, then a capture in the transfer cycle.
    t    = {NUM_TAPS{8'hEE}};
    t[4] = 8'hFF;
    applyStimulus(9'h010, t);
    checkOutput("ovr set", 128'(overrun), 128'(1));
    checkOutput("ovr mask", 128'(fill_mask), 128'(9'h1FF));
    win_ready = 1'b1;
    t[4]      = 8'h44;
    applyStimulus(9'h010, t);
    win_ready = 1'b0;
    expCnt    = expCnt + 1'b1;
    checkOutput("xfer B data", 128'(win_data), 128'(b));
    checkOutput("xfer mask", 128'(fill_mask), 128'(9'h010));
    checkOutput("xfer valid", 128'(win_valid), 128'(1));
    checkOutput("xfer win_cnt", 128'(win_cnt), 128'(expCnt));
    checkOutput("xfer overrun sticky", 128'(overrun), 128'(1));

    // clear discards B and the partial bank.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    void'(expQ.pop_front());
    checkOutput("clr win_valid", 128'(win_valid), 128'(0));
    checkOutput("clr overrun", 128'(overrun), 128'(0));
    checkOutput("clr mask", 128'(fill_mask), 128'(0));
    checkOutput("clr win_cnt", 128'(win_cnt), 128'(expCnt));

    // Duplicate lane 0 in FILL: the first sample is kept.
    t    = {NUM_TAPS{8'hEE}};
    t[0] = 8'h05;
    applyStimulus(9'h001, t);
    t[0] = 8'h06;
    applyStimulus(9'h001, t);
    checkOutput("dup overrun", 128'(overrun), 128'(1));
    checkOutput("dup mask", 128'(fill_mask), 128'(9'h001));
    t    = mkWin(8'h30, 8'h01);
    t[0] = 8'h77;
    e    = t;
    e[0] = 8'h05;
    expQ.push_back(e);
    applyStimulus(9'h1FE, t);
    checkOutput("dup valid", 128'(win_valid), 128'(1));
    win_ready = 1'b1;
    applyStimulus('0, {NUM_TAPS{8'hEE}});
    win_ready = 1'b0;
    expCnt    = expCnt + 1'b1;
    checkOutput("dup win_cnt", 128'(win_cnt), 128'(expCnt));

    // Leave a window waiting and a partial bank, then apply an async reset mid-cycle.
    e = mkWin(8'h60, 8'h02);
    applyStimulus(9'h1FF, e);
    applyStimulus(9'h0FF, mkWin(8'h50, 8'h01));
    checkOutput("pre-rst mask", 128'(fill_mask), 128'(9'h0FF));
    checkOutput("pre-rst valid", 128'(win_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst mask", 128'(fill_mask), 128'(0));
    checkOutput("arst valid", 128'(win_valid), 128'(0));
    checkOutput("arst overrun", 128'(overrun), 128'(0));
    checkOutput("arst win_cnt", 128'(win_cnt), 128'(0));
    checkOutput("arst win_data", 128'(win_data), 128'(0));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    expCnt = '0;

    // The collector works normally after reset.
    win_ready = 1'b1;
    t = mkWin(8'hA0, 8'h01);
    expQ.push_back(t);
    applyStimulus(9'h1FF, t);
    applyStimulus('0, {NUM_TAPS{8'hEE}});
    expCnt = expCnt + 1'b1;
    checkOutput("post-rst win_cnt", 128'(win_cnt), 128'(expCnt));
    checkOutput("post-rst valid", 128'(win_valid), 128'(0));

    @(posedge clk);
    #1;
    checkOutput("queue drained", 128'(expQ.size()), 128'(0));

    errors = errors + monErrors;
    checks = checks + monChecks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_collector.md
# window_collector

Gathers the nine per-tap lane outputs of the pixel demux (data plus one-hot valid) back into one complete 3x3 window. Presents that window on a single valid/ready output toward the convolution MAC stage. A 9-slot fill bank feeds a one-window output register, so the next window fills while the current one waits on backpressure. Lanes have no ready, so a sample arriving for an occupied slot is dropped and flagged.

## Interface
- WIDTH, 8, bits per tap sample
- CNT_W, 16, width of emitted-window counter
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- lane_data  input  9*WIDTH  tap samples; tap k (k=0..8) at [k*WIDTH +: WIDTH]
- lane_valid  input  9  per-tap valid; several may assert in one cycle
- clear  input  1  synchronous flush: empties bank and output register, clears overrun
- win_data  output  9*WIDTH  packed window, tap k at [k*WIDTH +: WIDTH]
- win_valid  output  1  window available
- win_ready  input  1  consumer accepts window when win_valid && win_ready
- fill_mask  output  9  occupied bank slots
- overrun  output  1  sticky: a lane sample was dropped
- win_cnt  output  CNT_W  windows accepted by consumer, wraps modulo 2^CNT_W

## Operation
- Reset: fill_mask=0, bank=0, win_data=0, win_valid=0, overrun=0, win_cnt=0, state FILL.
- Slot k captures lane_data[k] when lane_valid[k] && !fill_mask[k]; sets fill_mask[k].
- lane_valid[k] with fill_mask[k]=1 and no same-cycle transfer: sample dropped, overrun<=1, slot keeps the old value.
- Define complete = &(fill_mask | accepted lane_valid).
- Output slot is free when !win_valid || win_ready.
- States:
  - FILL: bank incomplete. On complete && slot free, the window loads into win_data, win_valid<=1, fill_mask<=0, stay FILL. On complete && slot busy, the bank latches and the state goes to FULL.
  - FULL: bank holds a complete window. When the slot frees (win_ready), the bank moves to win_data, win_valid stays 1, fill_mask<=0, state goes to FILL.
- During the FULL→FILL transfer cycle, lane_valid[k] is captured into the just-emptied slot k; no overrun.
- In FULL with no transfer, every lane_valid is dropped and sets overrun.
- Consume: win_valid && win_ready with no new load → win_valid<=0. Each accepted window increments win_cnt, wrapping 2^CNT_W-1 → 0.
- clear: fill_mask<=0, win_valid<=0, overrun<=0, state FILL. Data registers may keep their stale values. clear takes priority over all same-cycle captures and loads; win_cnt is not cleared.

## Timing
- Latency: the completing lane sample at edge N gives win_valid=1 after edge N (one cycle, no bubble).
- Throughput: one window per cycle is possible only if all 9 lanes are valid every cycle. Normal demux traffic gives one window per 9 samples.
- win_data and win_valid are stable while win_valid && !win_ready.
- win_ready is a don't-care while win_valid=0.
- Async rst mid-window discards the bank and output immediately; outputs take reset values without waiting for a clock edge.
- All outputs are registered; there is no combinational path from lane_* or win_ready to any output.

## Structure
- Shared package conv_pkg:
  - NUM_TAPS=9
  - collector_state_e {FILL, FULL}
  - typedef tap_window_t as a packed [NUM_TAPS-1:0][WIDTH-1:0] window
- Single module; no sub-module. The per-slot capture is a generate loop.

## Test plan
- Sequential fill: WIDTH=8, lanes 0..8 get 10,20,..,90 one per cycle, win_ready=1 → win_valid high 1 cycle after lane 8, win_data taps = 10..90, win_cnt=1, overrun=0.
- All-at-once: all 9 lane_valid in one cycle with values 1..9 → window valid next cycle with taps 1..9. Repeating this for 3 cycles gives 3 back-to-back windows, win_cnt=3.
- Backpressure: win_ready=0, fill two windows A (taps=0x11) then B (taps=0x22) → state FULL. win_data stays 0x11s. Raising win_ready for one cycle makes win_data=0x22s, fill_mask=0, win_cnt=1.
- Overrun: in FULL, pulse lane_valid[4]=1 with data 0xFF → overrun=1 and the bank is unchanged. Next, lane_valid[4] in the same cycle as the FULL→FILL transfer → captured, fill_mask=9'h010, no new overrun.
- Duplicate lane in FILL: lane 0 valid twice (0x05 then 0x06) before completion → slot 0 keeps 0x05, overrun=1.
- Reset/clear: rst asserted mid-fill with fill_mask=9'h0FF → all outputs zero immediately. After a completed window with win_ready=0, clear → win_valid=0, overrun=0, win_cnt unchanged.
